mac_tile_sequencer: RTL and testbench

MAC_TILE_SEQUENCER -- requirements
Module: mac_tile_sequencer

---
 rtl/mac_tile_pkg.sv | 39 +++
 rtl/mac_lane.sv | 83 ++++++++
 rtl/mac_tile_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mac_tile_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tile_pkg.sv
// Purpose: shared types and arithmetic helpers for the MAC tile sequencer and its lanes.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
// Contents: FSM state enum, ACC_MAX/ACC_MIN limits, saturating add used when MAC_TILE_SAT_EN is defined.
package mac_tile_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Limits are returned in a 64-bit signed container so one function serves any ACC_W up to 62.
    function automatic logic signed [63:0] acc_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    // Full-precision add, then clamp into the signed acc_w range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 acc_w);
        logic signed [63:0] sum;
        sum = a + b;
        if (sum > acc_max(acc_w)) begin
            return acc_max(acc_w);
        end
        if (sum < acc_min(acc_w)) begin
            return acc_min(acc_w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// Purpose: one MAC lane -- weight buffer, signed multiplier, accumulator (and sticky overflow flag).
// Latency: weight write and accumulate both take effect at the next clk edge; buffer read is combinational.
// Backpressure: none; the sequencer only pulses w_we/mac_en on accepted handshakes.
// Ports: clk/rst; clr zeroes acc (and ovf); w_we/w_addr/w_din write the buffer; mac_en/rd_addr/a_din
//        accumulate a_din*buf[rd_addr]; acc is the running sum; ovf exists only with MAC_TILE_SAT_EN.
module mac_lane
    import mac_tile_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             w_we,
    input  logic [AW-1:0]    w_addr,
    input  logic [W-1:0]     w_din,
    input  logic             mac_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [W-1:0]     a_din,
    output logic [ACC_W-1:0] acc
`ifdef MAC_TILE_SAT_EN
    ,
    output logic             ovf
`endif
);

    // Weight storage is deliberately not reset: validity is tracked by w_loaded in the sequencer.
    logic [W-1:0] w_mem [2**AW];

    always_ff @(posedge clk) begin
        if (w_we) begin
            w_mem[w_addr] <= w_din;
        end
    end

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;

    assign prod = $signed(a_din) * $signed(w_mem[rd_addr]);
    assign acc  = acc_q;

`ifdef MAC_TILE_SAT_EN
    logic signed [63:0] sum_full;
    logic signed [63:0] sum_sat;
    logic               ovf_q;

    assign sum_full = 64'(acc_q) + 64'(prod);
    assign sum_sat  = sat_add(64'(acc_q), 64'(prod), ACC_W);
    assign ovf      = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (mac_en) begin
            acc_q <= sum_sat[ACC_W-1:0];
            // Flag only when clamping actually changed the result.
            ovf_q <= ovf_q | (sum_sat != sum_full);
        end
    end
`else
    logic signed [ACC_W-1:0] prod_ext;

    // Signed size cast sign-extends the 2W product into the accumulator width.
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (mac_en) begin
            acc_q <= acc_q + prod_ext;   // wraps modulo 2^ACC_W
        end
    end
`endif

endmodule

// File: rtl/mac_tile_sequencer.sv
// Purpose: sequences weight load, activation streaming and result drain over N_MACS parallel MAC lanes.
// Latency: last activation handshake to first res_valid is 1 cycle; drain emits one lane per accepted cycle.
// Backpressure: valid/ready on all three streams; res_data/res_lane/res_last hold while res_ready is low.
// Ports: clk, rst (async, active-high); start/k_len/reuse_w job request; abort cancel;
//        w_valid/w_ready/w_data weight rows; a_valid/a_ready/a_data activations;
//        res_valid/res_ready/res_data/res_lane/res_last results; busy, done; ovf per lane.
// Config: MAC_TILE_SAT_EN -- saturating accumulation and the ovf port; undefined gives wrapping, no ovf.
module mac_tile_sequencer
    import mac_tile_pkg::*;
#(
    parameter  int W      = 8,
    parameter  int ACC_W  = 16,
    parameter  int N_MACS = 4,
    parameter  int K_MAX  = 16,
    localparam int KW     = $clog2(K_MAX + 1),
    localparam int LW     = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  logic                reuse_w,
    input  logic                abort,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [N_MACS*W-1:0] w_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [W-1:0]        a_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic [LW-1:0]       res_lane,
    output logic                res_last,
    output logic                busy,
    output logic                done
`ifdef MAC_TILE_SAT_EN
    ,
    output logic [N_MACS-1:0]   ovf
`endif
);

    // Buffer address width; k never exceeds K_MAX-1 while addressing, so the low bits suffice.
    localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] klen_q;
    logic [KW-1:0] k_cnt;
    logic [KW-1:0] k_cnt_inc;
    logic [KW-1:0] klen_clamp;
    logic [LW-1:0] lane_cnt;
    logic          w_loaded;
    logic          k_last;
    logic          lane_last;
    logic          job_accept;
    logic          w_hs;
    logic          a_hs;
    logic          r_hs;
    logic          lane_clr;

    logic [ACC_W-1:0] acc_arr [N_MACS];

    // Stream handshakes are suppressed by abort so a cancelled cycle has no side effects.
    assign w_ready   = (state_q == LOAD_W);
    assign a_ready   = (state_q == STREAM);
    assign res_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    assign w_hs = w_valid && w_ready && !abort;
    assign a_hs = a_valid && a_ready && !abort;
    assign r_hs = res_valid && res_ready && !abort;

    assign k_cnt_inc  = k_cnt + KW'(1);
    assign k_last     = (k_cnt_inc == klen_q);
    assign lane_last  = (lane_cnt == LW'(N_MACS - 1));
    assign klen_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    assign res_lane = lane_cnt;
    assign res_last = res_valid && lane_last;

    // FSM next-state logic.
    always_comb begin
        state_d    = state_q;
        job_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    job_accept = 1'b1;
                    if (k_len == '0) begin
                        state_d = DRAIN;
                    end else if (reuse_w && w_loaded) begin
                        state_d = STREAM;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (w_hs && k_last) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (a_hs && k_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (r_hs && lane_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d    = IDLE;
            job_accept = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job length, element counter, drain lane counter and weight-valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            klen_q   <= '0;
            k_cnt    <= '0;
            lane_cnt <= '0;
            w_loaded <= 1'b0;
        end else if (abort) begin
            klen_q   <= '0;
            k_cnt    <= '0;
            lane_cnt <= '0;
            // A partial load leaves the buffer inconsistent, so it can no longer be reused.
            if (state_q == LOAD_W) begin
                w_loaded <= 1'b0;
            end
        end else begin
            if (job_accept) begin
                klen_q   <= klen_clamp;
                k_cnt    <= '0;
                lane_cnt <= '0;
            end
            if (w_hs) begin
                k_cnt <= k_last ? '0 : k_cnt_inc;
                if (k_last) begin
                    w_loaded <= 1'b1;
                end
            end
            if (a_hs) begin
                k_cnt <= k_last ? '0 : k_cnt_inc;
            end
            if (r_hs) begin
                lane_cnt <= lane_last ? '0 : lane_cnt + LW'(1);
            end
        end
    end

    assign lane_clr = job_accept || abort;

    for (genvar j = 0; j < N_MACS; j++) begin : g_lane
        mac_lane #(
            .W     (W),
            .ACC_W (ACC_W),
            .AW    (AW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (lane_clr),
            .w_we    (w_hs),
            .w_addr  (k_cnt[AW-1:0]),
            .w_din   (w_data[j*W +: W]),
            .mac_en  (a_hs),
            .rd_addr (k_cnt[AW-1:0]),
            .a_din   (a_data),
            .acc     (acc_arr[j])
`ifdef MAC_TILE_SAT_EN
            ,
            .ovf     (ovf[j])
`endif
        );
    end

    // Result mux; lane_cnt only moves on a handshake, which keeps the outputs stable under stall.
    always_comb begin
        res_data = '0;
        if (res_valid) begin
            for (int j = 0; j < N_MACS; j++) begin
                if (lane_cnt == LW'(j)) begin
                    res_data = acc_arr[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Purpose: self-checking bench for mac_tile_sequencer against a job-level arithmetic reference model.
// Latency: checks the 1-cycle activation-to-result latency and the one-cycle done pulse.
// Backpressure: exercises random valid gaps, res_ready stalls, abort and ignored start.
module tb_mac_tile_sequencer;

    localparam int W      = 8;
    localparam int ACC_W  = 16;
    localparam int N_MACS = 4;
    localparam int K_MAX  = 16;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int LW     = (N_MACS > 1) ? $clog2(N_MACS) : 1;
    localparam longint ACC_HI = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint ACC_LO = -(64'sd1 <<< (ACC_W - 1));

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [KW-1:0]       k_len;
    logic                reuse_w;
    logic                abort;
    logic                w_valid;
    logic                w_ready;
    logic [N_MACS*W-1:0] w_data;
    logic                a_valid;
    logic                a_ready;
    logic [W-1:0]        a_data;
    logic                res_valid;
    logic                res_ready;
    logic [ACC_W-1:0]    res_data;
    logic [LW-1:0]       res_lane;
    logic                res_last;
    logic                busy;
    logic                done;
`ifdef MAC_TILE_SAT_EN
    logic [N_MACS-1:0]   ovf;
`endif

    mac_tile_sequencer #(
        .W      (W),
        .ACC_W  (ACC_W),
        .N_MACS (N_MACS),
        .K_MAX  (K_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .reuse_w   (reuse_w),
        .abort     (abort),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_lane  (res_lane),
        .res_last  (res_last),
        .busy      (busy),
        .done      (done)
`ifdef MAC_TILE_SAT_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int w_rdy_cnt = 0;
    int done_cnt  = 0;

    // Reference state: weight rows/activations for the next job, and the model's view of the buffer.
    int w_rows [K_MAX][N_MACS];
    int a_vec  [K_MAX];
    int wbuf_m [N_MACS][K_MAX];
    bit w_loaded_m = 1'b0;
    int obs_res [N_MACS];

    always @(negedge clk) begin
        if (w_ready === 1'b1) w_rdy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_MACS*W-1:0] pack_row(input int k);
        logic [N_MACS*W-1:0] r;
        r = '0;
        for (int j = 0; j < N_MACS; j++) r[j*W +: W] = W'(w_rows[k][j]);
        return r;
    endfunction

    // Dot product of the activations with the modelled buffer, then wrap or clamp into ACC_W.
    function automatic longint lane_ref(input int j, input int kl, output bit sat);
        longint s;
        logic signed [ACC_W-1:0] t;
        s   = 0;
        sat = 1'b0;
        for (int k = 0; k < kl; k++) begin
            s = s + longint'(a_vec[k]) * longint'(wbuf_m[j][k]);
`ifdef MAC_TILE_SAT_EN
            if (s > ACC_HI) begin s = ACC_HI; sat = 1'b1; end
            else if (s < ACC_LO) begin s = ACC_LO; sat = 1'b1; end
`endif
        end
        t = ACC_W'(s);
        return longint'(t);
    endfunction

    task automatic rand_data();
        for (int k = 0; k < K_MAX; k++) begin
            a_vec[k] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < N_MACS; j++) w_rows[k][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // One job from start to done (or abort). abort_w/abort_a: element index at which to abort (-1 none).
    task automatic run_job(input string tag, input int kl, input bit reuse, input int stall_lane,
                           input int abort_w, input int abort_a, input bit gaps, input bit poke_start);
        int     kl_eff, k, guard, i, stall_left, wr0, dn0;
        bit     exp_load, hs, ab;
        longint exp_res [N_MACS];
        bit     exp_ovf [N_MACS];
        kl_eff   = (kl > K_MAX) ? K_MAX : kl;
        exp_load = (kl_eff != 0) && !(reuse && w_loaded_m);
        wr0 = w_rdy_cnt;
        dn0 = done_cnt;

        start   = 1'b1;
        k_len   = KW'(kl);
        reuse_w = reuse;
        @(negedge clk);
        start   = 1'b0;
        k_len   = KW'($urandom_range(0, 20));   // must have been latched already
        reuse_w = 1'($urandom_range(0, 1));
        chk({tag, "_busy"}, busy, 1);

        if (exp_load) begin
            k = 0; guard = 0; ab = 1'b0;
            while (k < kl_eff && guard < 200 && !ab) begin
                w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                w_data  = pack_row(k);
                ab      = (k == abort_w);
                abort   = ab;
                hs      = w_valid && w_ready && !ab;
                @(negedge clk);
                if (hs) begin
                    for (int j = 0; j < N_MACS; j++) wbuf_m[j][k] = w_rows[k][j];
                    k++;
                end
                guard++;
            end
            w_valid = 1'b0;
            abort   = 1'b0;
            if (ab) begin
                w_loaded_m = 1'b0;
                chk({tag, "_abort_idle"}, busy, 0);
                repeat (3) @(negedge clk);
                chk({tag, "_abort_nodone"}, done_cnt - dn0, 0);
                return;
            end
            chk({tag, "_load_cnt"}, k, kl_eff);
            w_loaded_m = 1'b1;
        end

        if (kl_eff != 0) begin
            k = 0; guard = 0; ab = 1'b0;
            while (k < kl_eff && guard < 200 && !ab) begin
                a_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                a_data  = W'(a_vec[k]);
                start   = poke_start && (k == 1);
                if (start) k_len = '0;
                ab      = (k == abort_a);
                abort   = ab;
                hs      = a_valid && a_ready && !ab;
                @(negedge clk);
                if (hs) k++;
                guard++;
            end
            a_valid = 1'b0;
            abort   = 1'b0;
            start   = 1'b0;
            if (ab) begin
                chk({tag, "_abort_idle"}, busy, 0);
                repeat (3) @(negedge clk);
                chk({tag, "_abort_nodone"}, done_cnt - dn0, 0);
                return;
            end
            chk({tag, "_stream_cnt"}, k, kl_eff);
        end

        for (int j = 0; j < N_MACS; j++) exp_res[j] = lane_ref(j, kl_eff, exp_ovf[j]);
        chk({tag, "_res_latency"}, res_valid, 1);

        i = 0; guard = 0; stall_left = 5;
        while (i < N_MACS && guard < 100) begin
            res_ready = 1'b1;
            if (i == stall_lane && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else if (gaps && $urandom_range(0, 3) == 0) begin
                res_ready = 1'b0;
            end
            chk({tag, "_res_valid"}, res_valid, 1);
            chk({tag, "_res_lane"}, res_lane, i);
            chk({tag, "_res_data"}, $signed(res_data), exp_res[i]);
            chk({tag, "_res_last"}, res_last, (i == N_MACS - 1));
            hs = res_valid && res_ready;
            if (hs) obs_res[i] = int'($signed(res_data));
            @(negedge clk);
            if (hs) i++;
            guard++;
        end
        res_ready = 1'b0;
        chk({tag, "_drain_cnt"}, i, N_MACS);
        chk({tag, "_done_pulse"}, done, 1);
`ifdef MAC_TILE_SAT_EN
        for (int j = 0; j < N_MACS; j++) chk({tag, "_ovf"}, ovf[j], exp_ovf[j]);
`endif
        @(negedge clk);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_count"}, done_cnt - dn0, 1);
        chk({tag, "_w_ready_seen"}, (w_rdy_cnt != wr0), exp_load);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; reuse_w = 1'b0; abort = 1'b0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_lane", res_lane, 0);
        chk("rst_res_last", res_last, 0);
`ifdef MAC_TILE_SAT_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed dot products from a hand-built weight table.
        rand_data();
        w_rows[0] = '{1, 2, 3, 4};
        w_rows[1] = '{1, 1, 1, 1};
        w_rows[2] = '{0, 0, 0, -1};
        a_vec[0] = 2; a_vec[1] = 3; a_vec[2] = 4;
        run_job("basic", 3, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        chk("basic_l0", obs_res[0], 5);
        chk("basic_l1", obs_res[1], 7);
        chk("basic_l2", obs_res[2], 9);
        chk("basic_l3", obs_res[3], 7);

        a_vec[0] = 1; a_vec[1] = 1; a_vec[2] = 1;
        run_job("reuse", 3, 1'b1, -1, -1, -1, 1'b0, 1'b0);
        chk("reuse_l0", obs_res[0], 2);
        chk("reuse_l3", obs_res[3], 4);

        run_job("klen0", 0, 1'b0, -1, -1, -1, 1'b0, 1'b0);

        // abort wins over start in the same cycle
        start = 1'b1; abort = 1'b1; k_len = KW'(3);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start", busy, 0);

        rand_data();
        run_job("klen20", 20, 1'b0, -1, -1, -1, 1'b0, 1'b0);

        rand_data();
        run_job("stall", 5, 1'b0, 2, -1, -1, 1'b0, 1'b0);

        rand_data();
        run_job("ab_stream", 3, 1'b0, -1, -1, 2, 1'b0, 1'b0);
        run_job("after_ab_stream", 3, 1'b1, -1, -1, -1, 1'b0, 1'b0);

        rand_data();
        run_job("ab_load", 3, 1'b0, -1, 2, -1, 1'b0, 1'b0);
        rand_data();
        run_job("after_ab_load", 3, 1'b1, -1, -1, -1, 1'b0, 1'b0);

        rand_data();
        run_job("start_poke", 4, 1'b0, -1, -1, -1, 1'b1, 1'b1);

        // Large same-sign products on lane 0: wraps by default, clamps with saturation.
        rand_data();
        for (int k = 0; k < K_MAX; k++) begin
            a_vec[k]     = 127;
            w_rows[k][0] = 127;
        end
        run_job("big", 16, 1'b0, -1, -1, -1, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int kl, aw, aa;
            rand_data();
            kl = int'($urandom_range(0, 20));
            aw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            aa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_job("rand", kl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)) - 1,
                    aw, aa, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
